// File: rtl/key_pkg.sv
// Shared types and constants for the push-button debounce path.
package key_pkg;

    typedef enum logic [1:0] {
        ST_HI   = 2'd0,
        FILT_LO = 2'd1,
        ST_LO   = 2'd2,
        FILT_HI = 2'd3
    } key_state_t;

    localparam logic        KEY_RELEASED        = 1'b1;
    localparam int unsigned DEBOUNCE_CYCLES_50M = 1_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous board inputs; both stages reset to RST_VAL.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Synchronizes and debounces the active-low push button; emits the debounced
// level, single-cycle press/release strobes and a press-toggled level.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50M
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key,
    output logic key_out,
    output logic key_press,
    output logic key_release,
    output logic key_toggle
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    key_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             key_out_nxt, press_nxt, release_nxt, toggle_nxt;

    sync_2ff #(
        .RST_VAL (KEY_RELEASED)
    ) u_sync (
        .clk (sys_clk),
        .rst (sys_rst),
        .d   (key),
        .q   (sync1)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= ST_HI;
            cnt         <= '0;
            key_out     <= KEY_RELEASED;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_toggle  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            key_out     <= key_out_nxt;
            key_press   <= press_nxt;
            key_release <= release_nxt;
            key_toggle  <= toggle_nxt;
        end
    end

    // A return to the stable level takes priority over acceptance on the last count.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        key_out_nxt = key_out;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        toggle_nxt  = key_toggle;

        case (state)
            ST_HI: begin
                if (!sync1) begin
                    state_nxt = FILT_LO;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            FILT_LO: begin
                if (sync1) begin
                    state_nxt = ST_HI;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = ST_LO;
                    cnt_nxt     = '0;
                    key_out_nxt = ~KEY_RELEASED;
                    press_nxt   = 1'b1;
                    toggle_nxt  = ~key_toggle;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_LO: begin
                if (sync1) begin
                    state_nxt = FILT_HI;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            FILT_HI: begin
                if (!sync1) begin
                    state_nxt = ST_LO;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = ST_HI;
                    cnt_nxt     = '0;
                    key_out_nxt = KEY_RELEASED;
                    release_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_HI;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule
